// File: rtl/wb_regfile_if.sv
// Bus bundle between the MEM/WB pipeline register and the write-back/register-file stage.
// The master side drives write-back and read requests. The slave side returns read data and forwarding info.
interface wb_regfile_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int COUNT_WIDTH = 32
);
    logic [DATA_WIDTH-1:0]  inResult;
    logic [DATA_WIDTH-1:0]  inReadData;
    logic [ADDR_WIDTH-1:0]  inWriteRegister;
    logic                   inMemToReg;
    logic                   inRegWrite;
    logic [ADDR_WIDTH-1:0]  readRegister1;
    logic [ADDR_WIDTH-1:0]  readRegister2;
    logic [ADDR_WIDTH-1:0]  debugRegister;
    logic [DATA_WIDTH-1:0]  readData1;
    logic [DATA_WIDTH-1:0]  readData2;
    logic [DATA_WIDTH-1:0]  debugData;
    logic [DATA_WIDTH-1:0]  writeData;
    logic                   writeValid;
    logic [COUNT_WIDTH-1:0] retireCount;

    modport master (
        output inResult, inReadData, inWriteRegister, inMemToReg, inRegWrite,
        output readRegister1, readRegister2, debugRegister,
        input  readData1, readData2, debugData, writeData, writeValid, retireCount
    );

    modport slave (
        input  inResult, inReadData, inWriteRegister, inMemToReg, inRegWrite,
        input  readRegister1, readRegister2, debugRegister,
        output readData1, readData2, debugData, writeData, writeValid, retireCount
    );
endinterface

// File: rtl/wb_regfile.sv
// Write-back mux plus the architectural register file. It has two bypassed ID read ports,
// one unbypassed debug port and a retired-write counter.
module wb_regfile #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int COUNT_WIDTH = 32
) (
    input logic         clock,
    input logic         reset,
    wb_regfile_if.slave bus
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]  regs_q [NUM_REGS];
    logic [COUNT_WIDTH-1:0] retireCount_q;
    logic [COUNT_WIDTH-1:0] retireCount_d;
    logic [DATA_WIDTH-1:0]  writeData;
    logic                   writeValid;

    always_comb begin
        writeData     = bus.inMemToReg ? bus.inReadData : bus.inResult;
        writeValid    = bus.inRegWrite && (bus.inWriteRegister != '0);
        retireCount_d = retireCount_q + COUNT_WIDTH'(1);
    end

    // Same-cycle writes are forwarded so that ID observes the value being committed.
    always_comb begin
        bus.readData1 = '0;
        bus.readData2 = '0;
        bus.debugData = '0;
        if (reset) begin
            if (bus.readRegister1 != '0) begin
                if (writeValid && bus.inWriteRegister == bus.readRegister1)
                    bus.readData1 = writeData;
                else
                    bus.readData1 = regs_q[bus.readRegister1];
            end
            if (bus.readRegister2 != '0) begin
                if (writeValid && bus.inWriteRegister == bus.readRegister2)
                    bus.readData2 = writeData;
                else
                    bus.readData2 = regs_q[bus.readRegister2];
            end
            if (bus.debugRegister != '0)
                bus.debugData = regs_q[bus.debugRegister];
        end
    end

    assign bus.writeData   = writeData;
    assign bus.writeValid  = writeValid;
    assign bus.retireCount = retireCount_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= '0;
            retireCount_q <= '0;
        end else if (writeValid) begin
            regs_q[bus.inWriteRegister] <= writeData;
            retireCount_q               <= retireCount_d;
        end
    end
endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile. A reference model predicts each read, and the prediction
// is queued before the DUT output settles. A 4-bit-counter instance covers counter wrap.
module tb_wb_regfile;
    logic clock = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    logic [31:0] expQ[$];
    logic [31:0] e;
    logic [31:0] mdl [32];
    logic [31:0] mcount;
    logic [3:0]  mcount4;

    always #5 clock = ~clock;

    wb_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .COUNT_WIDTH(32)) bus ();
    wb_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .COUNT_WIDTH(4))  bus4 ();

    assign bus4.inResult        = bus.inResult;
    assign bus4.inReadData      = bus.inReadData;
    assign bus4.inWriteRegister = bus.inWriteRegister;
    assign bus4.inMemToReg      = bus.inMemToReg;
    assign bus4.inRegWrite      = bus.inRegWrite;
    assign bus4.readRegister1   = bus.readRegister1;
    assign bus4.readRegister2   = bus.readRegister2;
    assign bus4.debugRegister   = bus.debugRegister;

    wb_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .COUNT_WIDTH(32)) dut (
        .clock(clock), .reset(reset), .bus(bus.slave));
    wb_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .COUNT_WIDTH(4)) dut4 (
        .clock(clock), .reset(reset), .bus(bus4.slave));

    // The bench stops the run if it goes past a safe time limit.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] selData();
        return bus.inMemToReg ? bus.inReadData : bus.inResult;
    endfunction

    function automatic logic [31:0] expRead(input logic [4:0] idx);
        if (!reset || idx == 5'd0) return 32'h0;
        if (bus.inRegWrite && bus.inWriteRegister != 5'd0 && bus.inWriteRegister == idx)
            return selData();
        return mdl[idx];
    endfunction

    function automatic logic [31:0] expDebug(input logic [4:0] idx);
        if (!reset || idx == 5'd0) return 32'h0;
        return mdl[idx];
    endfunction

    task automatic applyStimulus(input logic rst, input logic m2r, input logic rw,
                                 input logic [4:0] wr, input logic [31:0] alu,
                                 input logic [31:0] ld);
        reset               = rst;
        bus.inMemToReg      = m2r;
        bus.inRegWrite      = rw;
        bus.inWriteRegister = wr;
        bus.inResult        = alu;
        bus.inReadData      = ld;
    endtask

    task automatic setReads(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dbg);
        bus.readRegister1 = r1;
        bus.readRegister2 = r2;
        bus.debugRegister = dbg;
    endtask

    // The model is updated with the edge's effect, then the task waits for the edge.
    task automatic tick();
        if (!reset) begin
            for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
            mcount  = 32'h0;
            mcount4 = 4'h0;
        end else if (bus.inRegWrite && bus.inWriteRegister != 5'd0) begin
            mdl[bus.inWriteRegister] = selData();
            mcount  = mcount + 32'd1;
            mcount4 = mcount4 + 4'd1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_AAAA, 32'h0);
        setReads(5'd5, 5'd5, 5'd5);
        expQ.push_back(32'h0);
        expQ.push_back(32'h0000_AAAA);
        #2;
        checks++; e = expQ.pop_front();
        if (bus.readData1 !== e) begin errors++; $display("[TB] FAIL reset_rd1_bypass: got %h expected %h", bus.readData1, e); end
        checks++; e = expQ.pop_front();
        if (bus.writeData !== e) begin errors++; $display("[TB] FAIL reset_writeData: got %h expected %h", bus.writeData, e); end
        checks++;
        if (bus.writeValid !== 1'b1) begin errors++; $display("[TB] FAIL reset_writeValid: got %b expected 1", bus.writeValid); end
        tick();
        tick();
        expQ.push_back(32'h0);
        expQ.push_back(32'h0);
        checks++; e = expQ.pop_front();
        if (bus.retireCount !== e) begin errors++; $display("[TB] FAIL reset_count: got %h expected %h", bus.retireCount, e); end
        checks++; e = expQ.pop_front();
        if (bus.readData2 !== e) begin errors++; $display("[TB] FAIL reset_rd2_held: got %h expected %h", bus.readData2, e); end
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd5, 32'h0000_AAAA, 32'h0);
        expQ.push_back(32'h0);
        #2;
        checks++; e = expQ.pop_front();
        if (bus.debugData !== e) begin errors++; $display("[TB] FAIL reset_reg5: got %h expected %h", bus.debugData, e); end
    endtask

    task automatic test_basic_commit();
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd8, 32'h1234_5678, 32'hCAFE_0000);
        setReads(5'd1, 5'd2, 5'd8);
        expQ.push_back(32'h1234_5678);
        #2;
        checks++; e = expQ.pop_front();
        if (bus.writeData !== e) begin errors++; $display("[TB] FAIL basic_writeData: got %h expected %h", bus.writeData, e); end
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd8, 32'h0, 32'h0);
        setReads(5'd8, 5'd0, 5'd8);
        expQ.push_back(32'h1234_5678);
        expQ.push_back(32'h1234_5678);
        expQ.push_back(32'd1);
        #2;
        checks++; e = expQ.pop_front();
        if (bus.readData1 !== e) begin errors++; $display("[TB] FAIL basic_rd1: got %h expected %h", bus.readData1, e); end
        checks++; e = expQ.pop_front();
        if (bus.debugData !== e) begin errors++; $display("[TB] FAIL basic_debug: got %h expected %h", bus.debugData, e); end
        checks++; e = expQ.pop_front();
        if (bus.retireCount !== e) begin errors++; $display("[TB] FAIL basic_count: got %h expected %h", bus.retireCount, e); end
    endtask

    task automatic test_load_bypass();
        applyStimulus(1'b1, 1'b1, 1'b1, 5'd3, 32'h1111_1111, 32'hDEAD_BEEF);
        setReads(5'd3, 5'd3, 5'd3);
        expQ.push_back(32'hDEAD_BEEF);
        expQ.push_back(32'hDEAD_BEEF);
        expQ.push_back(32'h0);
        #2;
        checks++; e = expQ.pop_front();
        if (bus.readData1 !== e) begin errors++; $display("[TB] FAIL bypass_rd1: got %h expected %h", bus.readData1, e); end
        checks++; e = expQ.pop_front();
        if (bus.readData2 !== e) begin errors++; $display("[TB] FAIL bypass_rd2: got %h expected %h", bus.readData2, e); end
        checks++; e = expQ.pop_front();
        if (bus.debugData !== e) begin errors++; $display("[TB] FAIL bypass_debug_old: got %h expected %h", bus.debugData, e); end
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd3, 32'h0, 32'h0);
        expQ.push_back(32'hDEAD_BEEF);
        expQ.push_back(32'd2);
        #2;
        checks++; e = expQ.pop_front();
        if (bus.debugData !== e) begin errors++; $display("[TB] FAIL bypass_debug_new: got %h expected %h", bus.debugData, e); end
        checks++; e = expQ.pop_front();
        if (bus.retireCount !== e) begin errors++; $display("[TB] FAIL bypass_count: got %h expected %h", bus.retireCount, e); end
    endtask

    task automatic test_reg_zero();
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 32'h0);
        setReads(5'd0, 5'd0, 5'd0);
        expQ.push_back(32'h0);
        #2;
        checks++;
        if (bus.writeValid !== 1'b0) begin errors++; $display("[TB] FAIL zero_writeValid: got %b expected 0", bus.writeValid); end
        checks++; e = expQ.pop_front();
        if (bus.readData1 !== e) begin errors++; $display("[TB] FAIL zero_rd1_same: got %h expected %h", bus.readData1, e); end
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        expQ.push_back(32'h0);
        expQ.push_back(32'h0);
        expQ.push_back(32'd2);
        #2;
        checks++; e = expQ.pop_front();
        if (bus.readData2 !== e) begin errors++; $display("[TB] FAIL zero_rd2: got %h expected %h", bus.readData2, e); end
        checks++; e = expQ.pop_front();
        if (bus.debugData !== e) begin errors++; $display("[TB] FAIL zero_debug: got %h expected %h", bus.debugData, e); end
        checks++; e = expQ.pop_front();
        if (bus.retireCount !== e) begin errors++; $display("[TB] FAIL zero_count: got %h expected %h", bus.retireCount, e); end
    endtask

    task automatic test_counter_wrap();
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        tick();
        for (int i = 1; i <= 17; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 5'(i), 32'h100 + 32'(i), 32'h0);
            tick();
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        setReads(5'd17, 5'd1, 5'd16);
        expQ.push_back({28'h0, 4'd1});
        expQ.push_back(32'd17);
        expQ.push_back(32'h111);
        expQ.push_back(32'h101);
        #2;
        checks++; e = expQ.pop_front();
        if ({28'h0, bus4.retireCount} !== e) begin errors++; $display("[TB] FAIL wrap_count4: got %h expected %h", bus4.retireCount, e); end
        checks++; e = expQ.pop_front();
        if (bus.retireCount !== e) begin errors++; $display("[TB] FAIL wrap_count32: got %h expected %h", bus.retireCount, e); end
        checks++; e = expQ.pop_front();
        if (bus.readData1 !== e) begin errors++; $display("[TB] FAIL wrap_rd1: got %h expected %h", bus.readData1, e); end
        checks++; e = expQ.pop_front();
        if (bus.readData2 !== e) begin errors++; $display("[TB] FAIL wrap_rd2: got %h expected %h", bus.readData2, e); end
    endtask

    task automatic test_reset_mid();
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd9, 32'h55, 32'h0);
        setReads(5'd9, 5'd9, 5'd9);
        expQ.push_back(32'h0);
        #2;
        checks++; e = expQ.pop_front();
        if (bus.readData1 !== e) begin errors++; $display("[TB] FAIL mid_rd1_inreset: got %h expected %h", bus.readData1, e); end
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd9, 32'h66, 32'h0);
        expQ.push_back(32'h0);
        expQ.push_back(32'h0);
        #2;
        checks++; e = expQ.pop_front();
        if (bus.debugData !== e) begin errors++; $display("[TB] FAIL mid_reg9_cleared: got %h expected %h", bus.debugData, e); end
        checks++; e = expQ.pop_front();
        if (bus.retireCount !== e) begin errors++; $display("[TB] FAIL mid_count_cleared: got %h expected %h", bus.retireCount, e); end
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd9, 32'h0, 32'h0);
        expQ.push_back(32'h66);
        expQ.push_back(32'd1);
        #2;
        checks++; e = expQ.pop_front();
        if (bus.readData1 !== e) begin errors++; $display("[TB] FAIL mid_reg9_new: got %h expected %h", bus.readData1, e); end
        checks++; e = expQ.pop_front();
        if (bus.retireCount !== e) begin errors++; $display("[TB] FAIL mid_count_new: got %h expected %h", bus.retireCount, e); end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 60; n++) begin
            applyStimulus(($urandom_range(0, 15) != 0), 1'($urandom), 1'($urandom_range(0, 3) != 0),
                          5'($urandom), $urandom, $urandom);
            setReads(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            if ($urandom_range(0, 2) == 0) bus.readRegister1 = bus.inWriteRegister;
            expQ.push_back(expRead(bus.readRegister1));
            expQ.push_back(expRead(bus.readRegister2));
            expQ.push_back(expDebug(bus.debugRegister));
            expQ.push_back(mcount);
            #2;
            checks++; e = expQ.pop_front();
            if (bus.readData1 !== e) begin errors++; $display("[TB] FAIL b2b_rd1[%0d]: got %h expected %h", n, bus.readData1, e); end
            checks++; e = expQ.pop_front();
            if (bus.readData2 !== e) begin errors++; $display("[TB] FAIL b2b_rd2[%0d]: got %h expected %h", n, bus.readData2, e); end
            checks++; e = expQ.pop_front();
            if (bus.debugData !== e) begin errors++; $display("[TB] FAIL b2b_debug[%0d]: got %h expected %h", n, bus.debugData, e); end
            checks++; e = expQ.pop_front();
            if (bus.retireCount !== e) begin errors++; $display("[TB] FAIL b2b_count[%0d]: got %h expected %h", n, bus.retireCount, e); end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        mcount  = 32'h0;
        mcount4 = 4'h0;
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        setReads(5'd0, 5'd0, 5'd0);
        @(posedge clock);
        #1;
        test_reset();
        test_basic_commit();
        test_load_bypass();
        test_reg_zero();
        test_counter_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage and architectural register file: the consumer end of the MEM/WB pipeline register.
- Takes the MEM/WB outputs (ALU result, load data, destination register, memToReg and regWrite controls) and selects the write-back value.
- Commits that value to a 32-entry register file and serves the two ID-stage read ports with write-through bypass.
- Also exports the selected write-back value for EX forwarding and keeps a retired-write counter for debug.

Parameters:
- DATA_WIDTH, 32, register and data path width.
- ADDR_WIDTH, 5, register index width; register count = 2**ADDR_WIDTH.
- COUNT_WIDTH, 32, width of the retired-write counter.

Ports:
- clock  input  1  sole clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset; sampled on posedge clock.
- inResult  input  DATA_WIDTH  ALU result from MEM/WB.
- inReadData  input  DATA_WIDTH  memory load data from MEM/WB.
- inWriteRegister  input  ADDR_WIDTH  destination register index.
- inMemToReg  input  1  1 = write back inReadData, 0 = inResult.
- inRegWrite  input  1  1 = commit write this cycle.
- readRegister1  input  ADDR_WIDTH  ID read port 1 index.
- readRegister2  input  ADDR_WIDTH  ID read port 2 index.
- debugRegister  input  ADDR_WIDTH  debug read index.
- readData1  output  DATA_WIDTH  port 1 data.
- readData2  output  DATA_WIDTH  port 2 data.
- debugData  output  DATA_WIDTH  debug read data, no bypass.
- writeData  output  DATA_WIDTH  selected write-back value, for EX forwarding.
- writeValid  output  1  inRegWrite and inWriteRegister != 0.
- retireCount  output  COUNT_WIDTH  number of committed register writes.

Behaviour:
- Write-back mux (combinational): writeData = inMemToReg ? inReadData : inResult.
- writeValid = inRegWrite and (inWriteRegister != 0). Both outputs are independent of reset.
- Commit at posedge clock when reset = 1 and writeValid = 1:
  - reg[inWriteRegister] <= writeData.
  - retireCount <= retireCount + 1, wrapping modulo 2**COUNT_WIDTH without saturation.
- Register 0 is hardwired to zero:
  - Writes to index 0 are dropped and do not increment retireCount.
  - Any read of index 0 returns 0 on every port.
- Read ports (combinational, zero latency):
  - readDataN = 0 if readRegisterN = 0.
  - Else writeData if writeValid and inWriteRegister = readRegisterN (write-through bypass, so a same-cycle write is visible in ID).
  - Else reg[readRegisterN].
- Both read ports may address the same register and the write target in the same cycle; both return the bypassed value.
- debugData = reg[debugRegister] with no bypass; it shows the value committed as of the last edge, and 0 for index 0.
- Synchronous reset: at posedge clock with reset = 0:
  - All registers <= 0 and retireCount <= 0.
  - Any concurrent write is discarded; reset has priority.
- While reset is low, readData1, readData2 and debugData are forced to 0, including the bypass path.
- Reset deasserted mid-stream: the first edge with reset = 1 commits normally.
- No internal pipeline state besides the array and the counter; the block never stalls.

Test Plan:
- Reset: hold reset=0 for 2 edges with inRegWrite=1, inWriteRegister=5 -> reg5 reads 0, retireCount=0, readData1=0 during reset.
- Basic commit: inResult=0x1234_5678, inMemToReg=0, inRegWrite=1, inWriteRegister=8, one edge, then inRegWrite=0 -> readRegister1=8 gives 0x1234_5678, debugData(8)=0x1234_5678, retireCount=1.
- Load select plus bypass: inReadData=0xDEAD_BEEF, inMemToReg=1, inWriteRegister=3, readRegister1=readRegister2=3 before the edge -> both ports 0xDEAD_BEEF same cycle, debugData(3) old value until the edge, then 0xDEAD_BEEF.
- Register zero: inRegWrite=1, inWriteRegister=0, inResult=0xFFFF_FFFF -> writeValid=0, reads of 0 return 0 after the edge, retireCount unchanged.
- Counter wrap: COUNT_WIDTH=4, 17 valid writes -> retireCount=1.
- Reset mid-operation: reset=0 on the same edge as a write to reg 9 = 0x55 -> reg9=0, count=0. Next edge with reset=1 writes 0x66 -> reg9=0x66, count=1.
